conversor_bcd_sequencial: RTL and testbench



---
 rtl/conversor_bcd_sequencial.sv | 115 +++++++++++
 tb/tb_conversor_bcd_sequencial.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/conversor_bcd_sequencial.sv
// Sequential signed binary-to-BCD converter for the seven-segment path.
// Iterative double-dabble with a fixed 12-cycle start/busy/done handshake.
module conversor_bcd_sequencial #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [LARGURA-1:0] valor,
  output logic               ocupado,
  output logic               pronto,
  output logic               negativo,
  output logic               estouro,
  output logic [3:0]         centena,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade
);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] ABSOLUTO = 2'd1;
  localparam logic [1:0] CONVERTE = 2'd2;
  localparam logic [1:0] FINAL    = 2'd3;

  logic [1:0]         r_estado;
  logic [LARGURA-1:0] r_valor;
  logic               r_sinal;
  logic               r_nao_zero;
  logic               r_estouro;
  logic [9:0]         r_desloc;
  logic [11:0]        r_bcd;
  logic [3:0]         r_contador;

  logic [1:0]         w_proximo;
  logic [LARGURA-1:0] w_magnitude;
  logic [11:0]        w_bcd_ajust;

  function automatic logic [3:0] ajusta(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Most negative input wraps to 2^(LARGURA-1) when read as unsigned.
  assign w_magnitude = r_sinal ? (~r_valor + LARGURA'(1)) : r_valor;
  assign w_bcd_ajust = {ajusta(r_bcd[11:8]), ajusta(r_bcd[7:4]), ajusta(r_bcd[3:0])};

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      OCIOSO:   if (inicio) w_proximo = ABSOLUTO;
      ABSOLUTO: w_proximo = CONVERTE;
      CONVERTE: if (r_contador == 4'd9) w_proximo = FINAL;
      FINAL:    w_proximo = OCIOSO;
      default:  w_proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_valor    <= '0;
      r_sinal    <= 1'b0;
      r_nao_zero <= 1'b0;
      r_estouro  <= 1'b0;
      r_desloc   <= '0;
      r_bcd      <= '0;
      r_contador <= '0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
      negativo   <= 1'b0;
      estouro    <= 1'b0;
      centena    <= '0;
      dezena     <= '0;
      unidade    <= '0;
    end else begin
      r_estado <= w_proximo;
      ocupado  <= (w_proximo != OCIOSO);
      pronto   <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (inicio) begin
            r_valor <= valor;
            r_sinal <= valor[LARGURA-1];
          end
        end
        ABSOLUTO: begin
          r_nao_zero <= |w_magnitude;
          r_estouro  <= (w_magnitude > LARGURA'(999));
          r_desloc   <= w_magnitude[9:0];
          r_bcd      <= '0;
          r_contador <= '0;
        end
        CONVERTE: begin
          // Top bit of the adjusted accumulator falls off the shift.
          {r_bcd, r_desloc} <= {w_bcd_ajust, r_desloc} << 1;
          r_contador        <= r_contador + 4'd1;
        end
        FINAL: begin
          negativo <= r_sinal & r_nao_zero;
          estouro  <= r_estouro;
          pronto   <= 1'b1;
          if (r_estouro) begin
            centena <= 4'd9;
            dezena  <= 4'd9;
            unidade <= 4'd9;
          end else begin
            centena <= r_bcd[11:8];
            dezena  <= r_bcd[7:4];
            unidade <= r_bcd[3:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Directed bench for conversor_bcd_sequencial: vector table plus
// hand-written busy-ignore, reset-abort and back-to-back sequences.
module tb_conversor_bcd_sequencial;

  logic        clock;
  logic        reset;
  logic        inicio;
  logic [31:0] valor;
  logic        ocupado, pronto, negativo, estouro;
  logic [3:0]  centena, dezena, unidade;

  int checks = 0;
  int errors = 0;
  logic [11:0] prev_digitos = '0;

  conversor_bcd_sequencial #(.LARGURA(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .inicio   (inicio),
    .valor    (valor),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .negativo (negativo),
    .estouro  (estouro),
    .centena  (centena),
    .dezena   (dezena),
    .unidade  (unidade)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] v;
    logic        neg;
    logic        est;
    logic [11:0] dig;
  } vetor_t;

  vetor_t tabela [0:9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nome, atual, esperado);
    end
  endtask

  function automatic logic [11:0] digitos();
    return {centena, dezena, unidade};
  endfunction

  // Edge T: start request sampled; input scrambled afterwards.
  task automatic inicia(input logic [31:0] v);
    inicio = 1'b1;
    valor  = v;
    tick();
    inicio = 1'b0;
    valor  = $urandom;
    chk("ocupado_T", 32'(ocupado), 32'd1);
    chk("pronto_T", 32'(pronto), 32'd0);
  endtask

  // Edges T+1..T+12; result checked right after T+12.
  task automatic espera(input logic neg, input logic est, input logic [11:0] dig);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("ocupado_T%0d", k), 32'(ocupado), 32'd1);
      chk($sformatf("pronto_T%0d", k), 32'(pronto), 32'd0);
      if (k == 6) chk("hold_digits", 32'(digitos()), 32'(prev_digitos));
    end
    tick();
    chk("pronto_T12", 32'(pronto), 32'd1);
    chk("ocupado_T12", 32'(ocupado), 32'd0);
    chk("negativo", 32'(negativo), 32'(neg));
    chk("estouro", 32'(estouro), 32'(est));
    chk("digits", 32'(digitos()), 32'(dig));
    prev_digitos = dig;
  endtask

  initial begin
    tabela[0] = '{32'd123,        1'b0, 1'b0, 12'h123};
    tabela[1] = '{32'hFFFFFFD3,   1'b1, 1'b0, 12'h045};
    tabela[2] = '{32'd0,          1'b0, 1'b0, 12'h000};
    tabela[3] = '{32'd999,        1'b0, 1'b0, 12'h999};
    tabela[4] = '{32'd1000,       1'b0, 1'b1, 12'h999};
    tabela[5] = '{32'h80000000,   1'b1, 1'b1, 12'h999};
    tabela[6] = '{32'd1024,       1'b0, 1'b1, 12'h999};
    tabela[7] = '{-32'sd999,      1'b1, 1'b0, 12'h999};
    tabela[8] = '{32'd507,        1'b0, 1'b0, 12'h507};
    tabela[9] = '{-32'sd1000,     1'b1, 1'b1, 12'h999};

    reset  = 1'b1;
    inicio = 1'b0;
    valor  = '0;
    #23;
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_flags", 32'({negativo, estouro}), 32'd0);
    chk("rst_digits", 32'(digitos()), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_ocupado", 32'(ocupado), 32'd0);

    for (int i = 0; i < 10; i++) begin
      inicia(tabela[i].v);
      espera(tabela[i].neg, tabela[i].est, tabela[i].dig);
      tick();
      chk("pronto_T13", 32'(pronto), 32'd0);
    end

    // Start 7, pulse inicio with 500 at T+3 and T+8: both ignored.
    inicio = 1'b1;
    valor  = 32'd7;
    tick();
    valor = 32'd500;
    for (int k = 1; k <= 12; k++) begin
      inicio = (k == 3 || k == 8);
      tick();
      if (k < 12) begin
        chk("busy_ocupado", 32'(ocupado), 32'd1);
        chk("busy_pronto", 32'(pronto), 32'd0);
        chk("busy_hold", 32'(digitos()), 32'h999);
      end
    end
    inicio = 1'b0;
    chk("busy_pronto_T12", 32'(pronto), 32'd1);
    chk("busy_digits", 32'(digitos()), 32'h007);
    chk("busy_flags", 32'({negativo, estouro}), 32'd0);
    prev_digitos = 12'h007;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("no_queue_pronto", 32'(pronto), 32'd0);
      chk("no_queue_ocupado", 32'(ocupado), 32'd0);
    end

    // Reset at T+6 aborts the conversion of 250.
    inicia(32'd250);
    for (int k = 1; k <= 5; k++) tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_digits", 32'(digitos()), 32'd0);
    chk("abort_flags", 32'({pronto, negativo, estouro}), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    prev_digitos = '0;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("abort_no_pronto", 32'(pronto), 32'd0);
    end
    inicia(32'd250);
    espera(1'b0, 1'b0, 12'h250);
    tick();

    // Back-to-back: second start held during the pronto cycle.
    inicia(32'd321);
    espera(1'b0, 1'b0, 12'h321);
    inicia(-32'sd8);
    espera(1'b1, 1'b0, 12'h008);
    tick();
    chk("b2b_pronto_end", 32'(pronto), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
